icache_dm: RTL and testbench



---
 rtl/icache_dm_pkg.sv | 31 +++
 rtl/icache_dm_ram.sv | 44 ++++
 rtl/icache_dm.sv | 212 +++++++++++++++++++++
 tb/tb_icache_dm.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_dm_pkg.sv
// -----------------------------------------------------------------------------
// icache_dm_pkg
// Shared definitions for the direct-mapped instruction cache:
//   - fixed address / data widths of the CPU and memory-controller sides
//   - controller state encoding
//   - big-endian word select helper
// Index/tag field widths depend on the LINES parameter, so they are derived
// inside the modules that know LINES.
// -----------------------------------------------------------------------------
package icache_dm_pkg;

  localparam int CPU_AW  = 27;  // word address width
  localparam int MEM_AW  = 26;  // doubleword address width
  localparam int WORD_W  = 32;
  localparam int LINE_W  = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_FILL   = 3'd2,
    ST_DONE   = 3'd3,
    ST_TERR   = 3'd4
  } state_t;

  // Big-endian word order inside a line: the even word lives in the upper half.
  function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                  input logic             odd);
    return odd ? line[WORD_W-1:0] : line[LINE_W-1:WORD_W];
  endfunction

endpackage

// File: rtl/icache_dm_ram.sv
// -----------------------------------------------------------------------------
// icache_dm_ram
// Synchronous single-port RAM holding {tag, data} for every cache line.
// Registered read port, write-first: a write returns the new word on rdata.
// Written in the plain form synthesis tools map onto block RAM.
//
// Ports:
//   clk    in   clock
//   en     in   port enable (read or write this cycle)
//   we     in   write enable (qualified by en)
//   addr   in   line index
//   wdata  in   {tag, data} to store
//   rdata  out  {tag, data} read on the previous enabled cycle
// -----------------------------------------------------------------------------
module icache_dm_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 82
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // NOTE: neither the array nor its output register has a reset; a reset
  // would stop the tools from mapping this onto a block RAM. Stale contents
  // are harmless because the valid vector in the parent gates every hit.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata     <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/icache_dm.sv
// -----------------------------------------------------------------------------
// icache_dm
// Direct-mapped, read-only instruction cache between the CPU fetch stage and
// the instruction port of the memory controller. Hits complete one cycle after
// the request is sampled; a miss issues exactly one 64-bit read, fills the
// line and returns the requested word. Memory timeouts are passed to the CPU
// without touching the cache.
//
// Ports:
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   cpu_stb      in   fetch request, held with cpu_addr until ack/timeout
//   cpu_addr     in   27-bit word address {tag, index, word}
//   cpu_dout     out  fetched word, meaningful while cpu_ack=1
//   cpu_ack      out  one-cycle completion pulse
//   cpu_timeout  out  one-cycle memory-timeout pulse
//   inv          in   invalidate-all request pulse
//   mem_stb      out  doubleword read request to the memory controller
//   mem_addr     out  doubleword address (registered cpu_addr[26:1])
//   mem_din      in   doubleword read data
//   mem_ack      in   read complete
//   mem_timeout  in   read timed out
// -----------------------------------------------------------------------------
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int LINES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_stb,
  input  logic [CPU_AW-1:0] cpu_addr,
  output logic [WORD_W-1:0] cpu_dout,
  output logic              cpu_ack,
  output logic              cpu_timeout,
  input  logic              inv,
  output logic              mem_stb,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_din,
  input  logic              mem_ack,
  input  logic              mem_timeout
);

  localparam int IB    = $clog2(LINES);
  localparam int TB    = MEM_AW - IB;
  localparam int RAM_W = TB + LINE_W;

  // ---------------------------------------------------------------------------
  // State and registered request
  // ---------------------------------------------------------------------------
  state_t              state, state_nxt;
  logic [CPU_AW-1:0]   addr_q;
  logic [WORD_W-1:0]   word_q;
  logic [LINES-1:0]    valid;
  logic                inv_pend;

  logic [IB-1:0]       idx_q;
  logic [TB-1:0]       tag_q;

  assign idx_q = addr_q[IB:1];
  assign tag_q = addr_q[CPU_AW-1:IB+1];

  // ---------------------------------------------------------------------------
  // Tag/data RAM
  // ---------------------------------------------------------------------------
  logic                ram_en;
  logic                ram_we;
  logic [IB-1:0]       ram_addr;
  logic [RAM_W-1:0]    ram_wdata;
  logic [RAM_W-1:0]    ram_rdata;
  logic [TB-1:0]       rd_tag;
  logic [LINE_W-1:0]   rd_data;

  // Control events decoded from the current state.
  logic                take_req;   // IDLE samples a new fetch
  logic                inv_clr;    // IDLE services a pending invalidate
  logic                fill_we;    // FILL completes successfully
  logic                hit;

  assign inv_clr  = (state == ST_IDLE) && inv_pend;
  assign take_req = (state == ST_IDLE) && !inv_pend && cpu_stb;
  // mem_ack wins over a simultaneous mem_timeout.
  assign fill_we  = (state == ST_FILL) && mem_ack;

  // The only write happens in FILL, the only read in IDLE, so one port is
  // enough: the address comes from the live request or the registered one.
  assign ram_en    = take_req || fill_we;
  assign ram_we    = fill_we;
  assign ram_addr  = fill_we ? idx_q : cpu_addr[IB:1];
  assign ram_wdata = {tag_q, mem_din};

  icache_dm_ram #(
    .DEPTH (LINES),
    .AW    (IB),
    .DW    (RAM_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign rd_tag  = ram_rdata[RAM_W-1:LINE_W];
  assign rd_data = ram_rdata[LINE_W-1:0];
  assign hit     = valid[idx_q] && (rd_tag == tag_q);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        // A pending invalidate holds IDLE for one cycle; the request waits.
        if (!inv_pend && cpu_stb) state_nxt = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        state_nxt = hit ? ST_IDLE : ST_FILL;
      end
      ST_FILL: begin
        if (mem_ack)          state_nxt = ST_DONE;
        else if (mem_timeout) state_nxt = ST_TERR;
      end
      ST_DONE: state_nxt = ST_IDLE;
      ST_TERR: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    cpu_ack     = 1'b0;
    cpu_timeout = 1'b0;
    cpu_dout    = '0;
    mem_stb     = 1'b0;
    unique case (state)
      ST_LOOKUP: begin
        if (hit) begin
          cpu_ack  = 1'b1;
          cpu_dout = word_sel(rd_data, addr_q[0]);
        end
      end
      ST_FILL: mem_stb = 1'b1;
      ST_DONE: begin
        cpu_ack  = 1'b1;
        cpu_dout = word_q;
      end
      ST_TERR: cpu_timeout = 1'b1;
      default: ;
    endcase
  end

  // addr_q resets to zero, so mem_addr is also zero out of reset.
  assign mem_addr = addr_q[CPU_AW-1:1];

  // ---------------------------------------------------------------------------
  // Request address and fill word
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      word_q <= '0;
    end else begin
      if (take_req) addr_q <= cpu_addr;
      if (fill_we)  word_q <= word_sel(mem_din, addr_q[0]);
    end
  end

  // ---------------------------------------------------------------------------
  // Valid vector and deferred invalidate
  // ---------------------------------------------------------------------------
  // A fill that completes while an invalidate is pending still sets its valid
  // bit; the pending flag wipes it on the next IDLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (inv_clr) begin
      valid <= '0;
    end else if (fill_we) begin
      valid[idx_q] <= 1'b1;
    end
  end

  // A new inv arriving on the clearing cycle re-arms the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_pend <= 1'b0;
    end else begin
      inv_pend <= inv || (inv_pend && !inv_clr);
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// -----------------------------------------------------------------------------
// tb_icache_dm
// Directed bench for icache_dm (LINES = 256: index = addr[8:1], tag =
// addr[26:9]). Inputs change and outputs are sampled on the falling edge.
// Latency counts are falling edges after the request is presented, so a hit
// reports 1 and a miss reports memory latency + 2.
// -----------------------------------------------------------------------------
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_stb = 1'b0;
  logic [26:0] cpu_addr = '0;
  logic [31:0] cpu_dout;
  logic        cpu_ack;
  logic        cpu_timeout;
  logic        inv = 1'b0;
  logic        mem_stb;
  logic [25:0] mem_addr;
  logic [63:0] mem_din = '0;
  logic        mem_ack = 1'b0;
  logic        mem_timeout = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // Results of the most recent fetch() call.
  int          r_cyc;
  logic        r_ack;
  logic        r_tmo;
  logic [31:0] r_dout;
  int          r_stb_cycles;
  int          r_rises;
  logic        r_addr_bad;
  logic        r_overlap;

  always #5 clk = ~clk;

  icache_dm #(.LINES(256)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_stb     (cpu_stb),
    .cpu_addr    (cpu_addr),
    .cpu_dout    (cpu_dout),
    .cpu_ack     (cpu_ack),
    .cpu_timeout (cpu_timeout),
    .inv         (inv),
    .mem_stb     (mem_stb),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_ack     (mem_ack),
    .mem_timeout (mem_timeout)
  );

  // Presents a fetch (caller is at a falling edge) and plays the memory.
  // mode: 0 = ack, 1 = timeout, 2 = ack and timeout together.
  // The response is driven on the lat-th cycle of mem_stb. inv_at pulses inv
  // on that mem_stb cycle; abort_at returns early while mem_stb is still high.
  // cpu_stb is left high on return so back-to-back requests are possible.
  task automatic fetch(input logic [26:0] a, input int lat, input logic [63:0] d,
                       input int mode, input int inv_at, input int abort_at);
    logic finished = 1'b0;
    logic prev = mem_stb;
    cpu_stb = 1'b1;
    cpu_addr = a;
    r_cyc = 0; r_ack = 0; r_tmo = 0; r_dout = '0;
    r_stb_cycles = 0; r_rises = 0; r_addr_bad = 0; r_overlap = 0;
    while (!finished) begin
      @(negedge clk);
      r_cyc++;
      mem_ack = 1'b0;
      mem_timeout = 1'b0;
      inv = 1'b0;
      if (cpu_ack && cpu_timeout) r_overlap = 1'b1;
      if (cpu_ack) begin
        r_ack = 1'b1; r_dout = cpu_dout; finished = 1'b1;
      end else if (cpu_timeout) begin
        r_tmo = 1'b1; finished = 1'b1;
      end else if (r_cyc >= 200) begin
        finished = 1'b1;
      end
      if (mem_stb) begin
        if (!prev) r_rises++;
        r_stb_cycles++;
        if (mem_addr !== a[26:1]) r_addr_bad = 1'b1;
        if (r_stb_cycles == lat) begin
          mem_din = d;
          mem_ack = (mode != 1);
          mem_timeout = (mode != 0);
        end
        if (r_stb_cycles == inv_at) inv = 1'b1;
        if (r_stb_cycles == abort_at) finished = 1'b1;
      end
      prev = mem_stb;
    end
  endtask

  // Drops the request for one cycle; completion pulses must be gone by then.
  task automatic idle();
    cpu_stb = 1'b0;
    @(negedge clk);
    vectors++;
    if (cpu_ack !== 1'b0 || cpu_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL pulse_width: ack=%b timeout=%b, required 0 0", cpu_ack, cpu_timeout);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if (cpu_ack !== 1'b0 || cpu_timeout !== 1'b0 || mem_stb !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: ack=%b timeout=%b mem_stb=%b, required 0 0 0",
               cpu_ack, cpu_timeout, mem_stb);
    end
    vectors++;
    if (cpu_dout !== 32'h0 || mem_addr !== 26'h0) begin
      miscompares++;
      $display("FAIL reset_data: dout=%h mem_addr=%h, required 0 0", cpu_dout, mem_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cold_miss();
    fetch(27'h0000010, 5, 64'h11223344_55667788, 0, 0, 0);
    vectors++;
    if (r_ack !== 1'b1 || r_dout !== 32'h11223344) begin
      miscompares++;
      $display("FAIL cold_miss_data: ack=%b dout=%h, required 1 11223344", r_ack, r_dout);
    end
    vectors++;
    if (r_cyc != 7) begin
      miscompares++;
      $display("FAIL cold_miss_latency: %0d cycles, required 7", r_cyc);
    end
    vectors++;
    if (r_rises != 1 || r_stb_cycles != 5 || r_addr_bad !== 1'b0) begin
      miscompares++;
      $display("FAIL cold_miss_mem: bursts=%0d stb_cycles=%0d addr_bad=%b, required 1 5 0",
               r_rises, r_stb_cycles, r_addr_bad);
    end
    idle();
  endtask

  task automatic test_hit_other_word();
    fetch(27'h0000011, 100, 64'h0, 0, 0, 0);
    vectors++;
    if (r_ack !== 1'b1 || r_dout !== 32'h55667788 || r_cyc != 1 || r_rises != 0) begin
      miscompares++;
      $display("FAIL hit_odd_word: ack=%b dout=%h cycles=%0d bursts=%0d, required 1 55667788 1 0",
               r_ack, r_dout, r_cyc, r_rises);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    fetch(27'h0000010, 100, 64'h0, 0, 0, 0);
    vectors++;
    if (r_dout !== 32'h11223344 || r_cyc != 1) begin
      miscompares++;
      $display("FAIL b2b_first: dout=%h cycles=%0d, required 11223344 1", r_dout, r_cyc);
    end
    // Next address presented at the ack edge: one IDLE cycle precedes the hit.
    fetch(27'h0000011, 100, 64'h0, 0, 0, 0);
    vectors++;
    if (r_dout !== 32'h55667788 || r_cyc != 2 || r_rises != 0) begin
      miscompares++;
      $display("FAIL b2b_second: dout=%h cycles=%0d bursts=%0d, required 55667788 2 0",
               r_dout, r_cyc, r_rises);
    end
    idle();
  endtask

  task automatic test_conflict();
    // 0x200 -> index 0, tag 1: separate line from 0x010 (index 8).
    fetch(27'h0000200, 3, 64'hAAAA0000_BBBB1111, 0, 0, 0);
    vectors++;
    if (r_dout !== 32'hAAAA0000 || r_cyc != 5 || r_rises != 1) begin
      miscompares++;
      $display("FAIL fill_idx0: dout=%h cycles=%0d bursts=%0d, required AAAA0000 5 1",
               r_dout, r_cyc, r_rises);
    end
    idle();
    fetch(27'h0000010, 100, 64'h0, 0, 0, 0);
    vectors++;
    if (r_cyc != 1 || r_dout !== 32'h11223344) begin
      miscompares++;
      $display("FAIL idx8_kept: cycles=%0d dout=%h, required 1 11223344", r_cyc, r_dout);
    end
    idle();
    // 0x211 -> index 8, tag 1: evicts the line holding 0x010/0x011.
    fetch(27'h0000211, 4, 64'hCCCC2222_DDDD3333, 0, 0, 0);
    vectors++;
    if (r_dout !== 32'hDDDD3333 || r_cyc != 6 || r_rises != 1) begin
      miscompares++;
      $display("FAIL conflict_fill: dout=%h cycles=%0d bursts=%0d, required DDDD3333 6 1",
               r_dout, r_cyc, r_rises);
    end
    idle();
    fetch(27'h0000010, 2, 64'h11223344_55667788, 0, 0, 0);
    vectors++;
    if (r_dout !== 32'h11223344 || r_cyc != 4 || r_rises != 1) begin
      miscompares++;
      $display("FAIL conflict_refetch: dout=%h cycles=%0d bursts=%0d, required 11223344 4 1",
               r_dout, r_cyc, r_rises);
    end
    idle();
    fetch(27'h0000201, 100, 64'h0, 0, 0, 0);
    vectors++;
    if (r_dout !== 32'hBBBB1111 || r_cyc != 1) begin
      miscompares++;
      $display("FAIL idx0_kept: dout=%h cycles=%0d, required BBBB1111 1", r_dout, r_cyc);
    end
    idle();
  endtask

  task automatic test_timeout();
    fetch(27'h0000030, 3, 64'hFFFFFFFF_FFFFFFFF, 1, 0, 0);
    vectors++;
    if (r_tmo !== 1'b1 || r_ack !== 1'b0 || r_cyc != 5 || r_overlap !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout: tmo=%b ack=%b cycles=%0d overlap=%b, required 1 0 5 0",
               r_tmo, r_ack, r_cyc, r_overlap);
    end
    idle();
    fetch(27'h0000030, 2, 64'h0BADF00D_CAFE0001, 0, 0, 0);
    vectors++;
    if (r_ack !== 1'b1 || r_dout !== 32'h0BADF00D || r_cyc != 4 || r_rises != 1) begin
      miscompares++;
      $display("FAIL timeout_refetch: ack=%b dout=%h cycles=%0d bursts=%0d, required 1 0BADF00D 4 1",
               r_ack, r_dout, r_cyc, r_rises);
    end
    idle();
    // ack and timeout together: ack wins and the line is filled.
    fetch(27'h0000040, 2, 64'h12345678_9ABCDEF0, 2, 0, 0);
    vectors++;
    if (r_ack !== 1'b1 || r_tmo !== 1'b0 || r_dout !== 32'h12345678 || r_overlap !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_wins: ack=%b tmo=%b dout=%h overlap=%b, required 1 0 12345678 0",
               r_ack, r_tmo, r_dout, r_overlap);
    end
    idle();
    fetch(27'h0000041, 100, 64'h0, 0, 0, 0);
    vectors++;
    if (r_dout !== 32'h9ABCDEF0 || r_cyc != 1) begin
      miscompares++;
      $display("FAIL ack_wins_hit: dout=%h cycles=%0d, required 9ABCDEF0 1", r_dout, r_cyc);
    end
    idle();
  endtask

  task automatic test_invalidate();
    fetch(27'h0000050, 4, 64'h50505050_A5A5A5A5, 0, 2, 0);
    vectors++;
    if (r_ack !== 1'b1 || r_dout !== 32'h50505050 || r_cyc != 6) begin
      miscompares++;
      $display("FAIL inv_fill: ack=%b dout=%h cycles=%0d, required 1 50505050 6", r_ack, r_dout, r_cyc);
    end
    idle();
    // Pending invalidate costs one IDLE cycle before the request is sampled.
    fetch(27'h0000051, 3, 64'h50505050_A5A5A5A5, 0, 0, 0);
    vectors++;
    if (r_dout !== 32'hA5A5A5A5 || r_cyc != 6 || r_rises != 1) begin
      miscompares++;
      $display("FAIL inv_refetch: dout=%h cycles=%0d bursts=%0d, required A5A5A5A5 6 1",
               r_dout, r_cyc, r_rises);
    end
    idle();
    fetch(27'h0000201, 2, 64'hAAAA0000_BBBB1111, 0, 0, 0);
    vectors++;
    if (r_dout !== 32'hBBBB1111 || r_rises != 1) begin
      miscompares++;
      $display("FAIL inv_all_lines: dout=%h bursts=%0d, required BBBB1111 1", r_dout, r_rises);
    end
    idle();
  endtask

  task automatic test_reset_mid_fill();
    fetch(27'h0000010, 100, 64'h0, 0, 0, 2);
    vectors++;
    if (mem_stb !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_fill_pre: mem_stb=%b, required 1", mem_stb);
    end
    cpu_stb = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (mem_stb !== 1'b0 || cpu_ack !== 1'b0 || cpu_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_fill_reset: mem_stb=%b ack=%b timeout=%b, required 0 0 0",
               mem_stb, cpu_ack, cpu_timeout);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_din = 64'hDEADBEEF_DEADBEEF;
    mem_ack = 1'b1;  // late ack for the aborted fill
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    vectors++;
    if (cpu_ack !== 1'b0 || mem_stb !== 1'b0) begin
      miscompares++;
      $display("FAIL stray_ack: ack=%b mem_stb=%b, required 0 0", cpu_ack, mem_stb);
    end
    fetch(27'h0000010, 2, 64'h11223344_55667788, 0, 0, 0);
    vectors++;
    if (r_dout !== 32'h11223344 || r_cyc != 4 || r_rises != 1) begin
      miscompares++;
      $display("FAIL post_reset_miss: dout=%h cycles=%0d bursts=%0d, required 11223344 4 1",
               r_dout, r_cyc, r_rises);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit_other_word();
    test_back_to_back();
    test_conflict();
    test_timeout();
    test_invalidate();
    test_reset_mid_fill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
